// File: rtl/fetch_pkg.sv
// Shared types and default constants for the IF-stage fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    HALTED   = 2'd2,
    REDIRECT = 2'd3
  } fetch_state_t;

  localparam int DEFAULT_MEMORY_ADDR_SIZE = 13;
  localparam int DEFAULT_RESET_ADDR       = 0;
  localparam int DEFAULT_PC_STEP          = 1;
  localparam int DEFAULT_TIMEOUT_CYCLES   = 16;

endpackage

// File: rtl/fetch_sequencer_timeout.sv
// Ack watchdog: counts consecutive unanswered request cycles and flags the
// cycle on which the limit is reached. The count drops to zero whenever count_en is low.
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  output logic expired_o
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    expired_o = count_en && (cnt_q == LAST);
    cnt_d     = '0;
    if (count_en && !expired_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage PC controller: sequential advance, branch redirect, stall, halt.
// Define FETCH_TIMEOUT_EN to add the ack watchdog and the fetch_err_o port.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int MEMORY_ADDR_SIZE = DEFAULT_MEMORY_ADDR_SIZE,
  parameter int RESET_ADDR       = DEFAULT_RESET_ADDR,
  parameter int PC_STEP          = DEFAULT_PC_STEP
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES   = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_i,
  input  logic                        branch_taken_i,
  input  logic [MEMORY_ADDR_SIZE-1:0] branch_target_i,
  input  logic                        halt_i,
  input  logic                        resume_i,
  input  logic                        imem_ack_i,
`ifdef FETCH_TIMEOUT_EN
  output logic                        fetch_err_o,
`endif
  output logic                        imem_req_o,
  output logic [MEMORY_ADDR_SIZE-1:0] pc_o,
  output logic [MEMORY_ADDR_SIZE-1:0] next_pc_o,
  output logic                        pc_en_o,
  output logic                        flush_o,
  output logic [1:0]                  state_o
);

  localparam logic [MEMORY_ADDR_SIZE-1:0] RST_PC = MEMORY_ADDR_SIZE'(RESET_ADDR);
  localparam logic [MEMORY_ADDR_SIZE-1:0] STEP   = MEMORY_ADDR_SIZE'(PC_STEP);

  fetch_state_t                state_q, state_d;
  logic [MEMORY_ADDR_SIZE-1:0] pc_q, pc_d;
  logic                        pc_en_q, pc_en_d;
  logic                        flush_q, flush_d;
  logic                        wd_expired;
  logic                        resume_ok;

`ifdef FETCH_TIMEOUT_EN
  logic wd_count;
  logic err_q, err_d;

  // Only a live, unanswered request with nothing of higher priority keeps the count going.
  assign wd_count = (state_q == FETCH) && !branch_taken_i && !halt_i
                    && !stall_i && !imem_ack_i;

  fetch_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .count_en  (wd_count),
    .expired_o (wd_expired)
  );

  assign err_d       = err_q | wd_expired;
  assign resume_ok   = !err_q;
  assign fetch_err_o = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign wd_expired = 1'b0;
  assign resume_ok  = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_en_d    = 1'b0;
    flush_d    = 1'b0;
    imem_req_o = 1'b0;
    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        imem_req_o = !stall_i;
        if (branch_taken_i) begin
          pc_d    = branch_target_i;
          pc_en_d = 1'b1;
          flush_d = 1'b1;
          state_d = REDIRECT;
        end else if (halt_i) begin
          state_d = HALTED;
        end else if (stall_i) begin
          state_d = FETCH;
        end else if (imem_ack_i) begin
          pc_d    = pc_q + STEP;
          pc_en_d = 1'b1;
        end else if (wd_expired) begin
          state_d = HALTED;
        end
      end
      HALTED:   if (resume_i && resume_ok) state_d = FETCH;
      REDIRECT: state_d = FETCH;
      default:  state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RST_PC;
      pc_en_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_en_q <= pc_en_d;
      flush_q <= flush_d;
    end
  end

  // Reflects reset so the output always names the value pc_o will hold after the edge.
  assign next_pc_o = rst ? RST_PC : pc_d;
  assign pc_o      = pc_q;
  assign pc_en_o   = pc_en_q;
  assign flush_o   = flush_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a rule-level reference model.
module tb_fetch_sequencer;

  localparam int AW  = 13;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall_i = 1'b0;
  logic          branch_taken_i = 1'b0;
  logic [AW-1:0] branch_target_i = '0;
  logic          halt_i = 1'b0;
  logic          resume_i = 1'b0;
  logic          imem_ack_i = 1'b0;
  logic          imem_req_o;
  logic [AW-1:0] pc_o;
  logic [AW-1:0] next_pc_o;
  logic          pc_en_o;
  logic          flush_o;
  logic [1:0]    state_o;
`ifdef FETCH_TIMEOUT_EN
  logic          fetch_err_o;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .halt_i          (halt_i),
    .resume_i        (resume_i),
    .imem_ack_i      (imem_ack_i),
`ifdef FETCH_TIMEOUT_EN
    .fetch_err_o     (fetch_err_o),
`endif
    .imem_req_o      (imem_req_o),
    .pc_o            (pc_o),
    .next_pc_o       (next_pc_o),
    .pc_en_o         (pc_en_o),
    .flush_o         (flush_o),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state 0 boot, 1 fetch, 2 halted, 3 redirect.
  int m_state = 0;
  int m_pc    = 0;
  bit m_en    = 0;
  bit m_flush = 0;
  bit m_valid = 0;
  bit m_err   = 0;
  int m_wait  = 0;

  function automatic bit fetch_idle();
    return m_state == 1 && !branch_taken_i && !halt_i && !stall_i && !imem_ack_i;
  endfunction

  function automatic bit timed_out();
`ifdef FETCH_TIMEOUT_EN
    return fetch_idle() && (m_wait == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit advancing();
    return m_state == 1 && !branch_taken_i && !halt_i && !stall_i && imem_ack_i;
  endfunction

  function automatic int exp_state();
    if (rst) return 0;
    case (m_state)
      0: return 1;
      1: if (branch_taken_i) return 3;
         else if (halt_i || timed_out()) return 2;
         else return 1;
      2: return (resume_i && !m_err) ? 1 : 2;
      default: return 1;
    endcase
  endfunction

  function automatic int exp_pc();
    if (rst) return 0;
    if (m_state == 1 && branch_taken_i) return int'(branch_target_i);
    if (advancing()) return (m_pc + 1) % (1 << AW);
    return m_pc;
  endfunction

  function automatic bit exp_en();
    return !rst && (advancing() || (m_state == 1 && branch_taken_i));
  endfunction

  always @(posedge clk) begin
    m_state <= exp_state();
    m_pc    <= exp_pc();
    m_en    <= exp_en();
    m_flush <= !rst && m_state == 1 && branch_taken_i;
    m_valid <= m_valid | rst;
`ifdef FETCH_TIMEOUT_EN
    m_wait  <= (rst || !fetch_idle() || timed_out()) ? 0 : m_wait + 1;
    m_err   <= !rst && (m_err || timed_out());
`endif
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("state", state_o, m_state);
      chk("pc", pc_o, m_pc);
      chk("pc_en", pc_en_o, m_en);
      chk("flush", flush_o, m_flush);
      chk("req", imem_req_o, (m_state == 1 && !stall_i) ? 1 : 0);
      chk("next_pc", next_pc_o, exp_pc());
`ifdef FETCH_TIMEOUT_EN
      chk("fetch_err", fetch_err_o, m_err);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic branch_to(input int tgt);
    branch_taken_i  = 1'b1;
    branch_target_i = AW'(tgt);
    tick(1);
    branch_taken_i  = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset and sequential advance
    tick(2);
    chk("lit_rst_state", state_o, 0);
    chk("lit_rst_pc", pc_o, 0);
    chk("lit_rst_pc_en", pc_en_o, 0);
    rst = 1'b0; imem_ack_i = 1'b1;
    tick(1);
    chk("lit_boot_to_fetch", state_o, 1);
    chk("lit_boot_pc", pc_o, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk("lit_seq_pc", pc_o, i);
      chk("lit_seq_en", pc_en_o, 1);
    end
    tick(2);
    chk("lit_pc5", pc_o, 5);

    // Branch with simultaneous ack; ack held through REDIRECT
    branch_taken_i = 1'b1; branch_target_i = 13'h100;
    tick(1);
    branch_taken_i = 1'b0;
    chk("lit_br_pc", pc_o, 'h100);
    chk("lit_br_flush", flush_o, 1);
    chk("lit_br_state", state_o, 3);
    tick(1);
    chk("lit_redir_exit", state_o, 1);
    chk("lit_redir_pc", pc_o, 'h100);
    chk("lit_redir_flush", flush_o, 0);
    imem_ack_i = 1'b0;

    // Stall with ack held high
    stall_i = 1'b1; imem_ack_i = 1'b1;
    tick(3);
    chk("lit_stall_pc", pc_o, 'h100);
    chk("lit_stall_en", pc_en_o, 0);
    stall_i = 1'b0;
    tick(1);
    imem_ack_i = 1'b0;
    chk("lit_unstall_pc", pc_o, 'h101);
    tick(1);
    chk("lit_hold_en", pc_en_o, 0);

    // Halt (with ack ignored), branch ignored while halted, resume
    branch_to(7);
    chk("lit_pc7", pc_o, 7);
    halt_i = 1'b1; imem_ack_i = 1'b1;
    tick(1);
    halt_i = 1'b0; imem_ack_i = 1'b0;
    chk("lit_halt_state", state_o, 2);
    chk("lit_halt_pc", pc_o, 7);
    branch_taken_i = 1'b1; branch_target_i = 13'h20;
    tick(1);
    branch_taken_i = 1'b0;
    chk("lit_halt_br_pc", pc_o, 7);
    chk("lit_halt_br_state", state_o, 2);
    resume_i = 1'b1;
    tick(1);
    resume_i = 1'b0;
    chk("lit_resume_state", state_o, 1);
    chk("lit_resume_pc", pc_o, 7);

    // Wrap at the top of the address space
    branch_to(8191);
    chk("lit_pc_max", pc_o, 8191);
    imem_ack_i = 1'b1;
    tick(1);
    imem_ack_i = 1'b0;
    chk("lit_wrap_pc", pc_o, 0);
    chk("lit_wrap_en", pc_en_o, 1);

    // Reset in the middle of an outstanding request
    branch_to(42);
    chk("lit_pc42", pc_o, 42);
    rst = 1'b1;
    tick(1);
    chk("lit_midrst_state", state_o, 0);
    chk("lit_midrst_pc", pc_o, 0);
    rst = 1'b0;
    tick(1);
    chk("lit_after_rst", state_o, 1);

`ifdef FETCH_TIMEOUT_EN
    tick(TO - 1);
    chk("lit_to_not_yet", state_o, 1);
    chk("lit_to_err0", fetch_err_o, 0);
    tick(1);
    chk("lit_to_state", state_o, 2);
    chk("lit_to_err1", fetch_err_o, 1);
    resume_i = 1'b1;
    tick(2);
    resume_i = 1'b0;
    chk("lit_to_resume_blocked", state_o, 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("lit_to_rst_err", fetch_err_o, 0);
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller for the IF-stage program counter.
- Each cycle, decides whether the PC advances sequentially, redirects to a branch target, holds for a stall, or halts.
- Drives the PC register's enable and next-address inputs.
- Runs the request/acknowledge handshake with instruction memory.
- Sits between the hazard/EX-stage control signals and the PC register / instruction memory.

Parameters:
MEMORY_ADDR_SIZE, 13, width of instruction addresses.
RESET_ADDR, 0, PC value loaded on reset.
PC_STEP, 1, sequential increment per fetched instruction.
TIMEOUT_CYCLES, 16, ack wait limit (used only with FETCH_TIMEOUT_EN).

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  reset, synchronous, active-high.
stall_i  in  1  hazard stall; hold PC, suppress new request.
branch_taken_i  in  1  EX-stage redirect strobe.
branch_target_i  in  MEMORY_ADDR_SIZE  redirect address, valid with branch_taken_i.
halt_i  in  1  halt-instruction decoded.
resume_i  in  1  leave HALTED.
imem_ack_i  in  1  instruction memory completed current request.
imem_req_o  out  1  fetch request at pc_o.
pc_o  out  MEMORY_ADDR_SIZE  current fetch address, registered.
next_pc_o  out  MEMORY_ADDR_SIZE  address the PC register loads this cycle.
pc_en_o  out  1  one-cycle load enable to the PC register.
flush_o  out  1  one-cycle pulse; IF/ID contents invalid.
state_o  out  2  current FSM state (debug).

Behaviour:
- Reset (rst=1 at a clk edge, any state, mid-request included):
  - state=BOOT, pc_o=RESET_ADDR.
  - pc_en_o=0, flush_o=0, imem_req_o=0.
  - Any outstanding request is abandoned.
- FSM states: BOOT(0), FETCH(1), HALTED(2), REDIRECT(3).
- BOOT -> FETCH unconditionally on the next cycle.
- In FETCH:
  - imem_req_o = !stall_i, combinational from the registered state.
  - Priority per cycle: branch_taken_i > halt_i > stall_i > imem_ack_i.
- branch_taken_i=1 in FETCH:
  - Next cycle: pc_o=branch_target_i, pc_en_o=1, flush_o=1, state=REDIRECT.
  - An ack in the same cycle is ignored.
- REDIRECT: imem_req_o=0 for exactly one cycle, then FETCH. Further branch_taken_i in REDIRECT is ignored.
- halt_i=1 in FETCH (no branch that cycle):
  - state=HALTED, pc held, no pc_en_o pulse.
  - Any ack in the same cycle is ignored.
- HALTED:
  - imem_req_o=0; branch_taken_i and stall_i are ignored.
  - resume_i=1 -> FETCH with pc_o unchanged.
- stall_i=1 in FETCH (no branch/halt): pc held, pc_en_o=0. An ack in the same cycle is ignored.
- imem_ack_i=1 with imem_req_o=1 (no higher-priority event):
  - Next cycle: pc_o = (pc_o + PC_STEP) mod 2^MEMORY_ADDR_SIZE, pc_en_o=1 for one cycle.
  - Wrap: 8191 + 1 -> 0 at the default width; no error flag.
- Ack received while imem_req_o=0 is ignored.
- next_pc_o is combinational: the value pc_o takes at the next edge, equal to pc_o when holding.
- Latency: ack at cycle N -> new pc_o and pc_en_o visible at cycle N+1 -> new request at N+1.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - Adds output fetch_err_o (1 bit, reset 0).
  - A counter increments each FETCH cycle with imem_req_o=1 and no ack; it clears on ack, branch, stall, or state exit.
  - When the count reaches TIMEOUT_CYCLES: fetch_err_o=1 (sticky until rst), state=HALTED.
  - resume_i does not leave HALTED while fetch_err_o=1.
- Undefined: no port, no counter; the sequencer waits indefinitely for ack.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum (BOOT, FETCH, HALTED, REDIRECT).
  - MEMORY_ADDR_SIZE default constant.
  - RESET_ADDR default constant.
- Sub-module fetch_timeout_counter: counter plus compare, instantiated only under FETCH_TIMEOUT_EN.
- The next-PC mux stays in fetch_sequencer.

Test Plan:
1. rst 2 cycles, release, ack every request -> pc_o 0,1,2,3 on consecutive acks; pc_en_o pulses once per ack; flush_o stays 0.
2. pc_o=5, branch_taken_i=1 with target 0x100 and simultaneous ack -> pc_o=0x100, flush_o one pulse, imem_req_o low one cycle, then FETCH at 0x100.
3. stall_i high 3 cycles with ack held high -> pc_o constant, imem_req_o=0, no pc_en_o; after release, one ack advances by 1.
4. halt_i at pc_o=7 -> HALTED, req 0; branch to 0x20 ignored; resume_i -> FETCH at 7.
5. Force pc_o=8191 via branch, ack -> pc_o=0; rst asserted mid-request at pc_o=42 -> pc_o=0, state BOOT next cycle.
6. FETCH_TIMEOUT_EN defined, no ack for 16 cycles -> fetch_err_o=1, HALTED; resume_i ignored; rst clears fetch_err_o.
